// File: rtl/ftdi_fifo_bridge.sv
// ftdi_fifo_bridge: FT232H async-245 FIFO port controller with RX/TX buffers and round-robin arbitration.
// Define FTDI_BRIDGE_STATS_EN to build the 16-bit rx_count/tx_count traffic counters.
module ftdi_fifo_bridge #(
    parameter int DATA_W      = 8,
    parameter int RX_DEPTH    = 8,
    parameter int TX_DEPTH    = 8,
    parameter int SYNC_STAGES = 2,
    parameter int RD_PULSE    = 3,
    parameter int WR_SETUP    = 1,
    parameter int WR_PULSE    = 2,
    parameter int RECOVER     = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ftdi_rxf,
    input  logic              ftdi_txe,
    output logic              ftdi_rd,
    output logic              ftdi_wr,
    input  logic [DATA_W-1:0] adbus_in,
    output logic [DATA_W-1:0] adbus_out,
    output logic              adbus_oe,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              busy,
    output logic [15:0]       rx_count,
    output logic [15:0]       tx_count
);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam logic [RX_AW:0] RX_FULL = (RX_AW+1)'(RX_DEPTH);
    localparam logic [TX_AW:0] TX_FULL = (TX_AW+1)'(TX_DEPTH);
    localparam logic [7:0] RD_LAST    = 8'(RD_PULSE - 1);
    localparam logic [7:0] SETUP_LAST = 8'(WR_SETUP - 1);
    localparam logic [7:0] WR_LAST    = 8'(WR_PULSE - 1);
    // The IDLE arbitration cycle completes the RECOVER+SYNC_STAGES quiet window.
    localparam logic [7:0] REC_LAST   = 8'(RECOVER + SYNC_STAGES - 2);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD_LOW   = 3'd1;
    localparam logic [2:0] S_WR_SETUP = 3'd2;
    localparam logic [2:0] S_WR_LOW   = 3'd3;
    localparam logic [2:0] S_WR_HOLD  = 3'd4;
    localparam logic [2:0] S_RECOVER  = 3'd5;

    logic [SYNC_STAGES-1:0] rxf_sync_q, rxf_sync_d, txe_sync_q, txe_sync_d;
    logic [2:0]             state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   last_wr_q, last_wr_d;
    logic [DATA_W-1:0]      rd_data_q, rd_data_d;
    logic                   rd_pend_q, rd_pend_d;
    logic                   rd_n_q, rd_n_d, wr_n_q, wr_n_d, oe_q, oe_d;
    logic [DATA_W-1:0]      out_q, out_d;
    logic [DATA_W-1:0]      rx_mem_q [RX_DEPTH];
    logic [DATA_W-1:0]      tx_mem_q [TX_DEPTH];
    logic [RX_AW-1:0]       rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [TX_AW-1:0]       tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [RX_AW:0]         rx_used_q, rx_used_d;
    logic [TX_AW:0]         tx_used_q, tx_used_d;
    logic                   rx_push, rx_pop, tx_push, tx_pop, rd_ok, wr_ok;

    assign rx_push   = rd_pend_q;
    assign rx_pop    = rx_valid & rx_ready;
    assign tx_push   = tx_valid & tx_ready;
    assign rx_valid  = rx_used_q != '0;
    assign tx_ready  = tx_used_q != TX_FULL;
    assign rx_data   = rx_mem_q[rx_rptr_q];
    assign rd_ok     = !rxf_sync_q[SYNC_STAGES-1] && rx_used_q != RX_FULL;
    assign wr_ok     = !txe_sync_q[SYNC_STAGES-1] && tx_used_q != '0;
    assign ftdi_rd   = rd_n_q;
    assign ftdi_wr   = wr_n_q;
    assign adbus_oe  = oe_q;
    assign adbus_out = out_q;
    assign busy      = state_q != S_IDLE;

    always_comb begin
        rxf_sync_d = {rxf_sync_q[SYNC_STAGES-2:0], ftdi_rxf};
        txe_sync_d = {txe_sync_q[SYNC_STAGES-2:0], ftdi_txe};
        rx_wptr_d  = rx_wptr_q + RX_AW'(rx_push);
        rx_rptr_d  = rx_rptr_q + RX_AW'(rx_pop);
        rx_used_d  = rx_used_q + (RX_AW+1)'(rx_push) - (RX_AW+1)'(rx_pop);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 8'd1;
        last_wr_d = last_wr_q;
        rd_data_d = rd_data_q;
        rd_pend_d = 1'b0;
        out_d     = out_q;
        tx_pop    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (rd_ok && (!wr_ok || last_wr_q)) begin
                    state_d   = S_RD_LOW;
                    last_wr_d = 1'b0;
                end else if (wr_ok) begin
                    state_d   = S_WR_SETUP;
                    last_wr_d = 1'b1;
                    out_d     = tx_mem_q[tx_rptr_q];
                end
            end
            S_RD_LOW: if (cnt_q == RD_LAST) begin
                state_d   = S_RECOVER;
                cnt_d     = '0;
                rd_data_d = adbus_in;
                rd_pend_d = 1'b1;
            end
            S_WR_SETUP: if (cnt_q == SETUP_LAST) begin
                state_d = S_WR_LOW;
                cnt_d   = '0;
            end
            S_WR_LOW: if (cnt_q == WR_LAST) begin
                state_d = S_WR_HOLD;
                cnt_d   = '0;
                tx_pop  = 1'b1;
            end
            S_WR_HOLD: begin
                state_d = S_RECOVER;
                cnt_d   = '0;
            end
            S_RECOVER: if (cnt_q == REC_LAST) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
        // Pad strobes are registered from the next state so they never glitch.
        rd_n_d    = state_d != S_RD_LOW;
        wr_n_d    = state_d != S_WR_LOW;
        oe_d      = state_d == S_WR_SETUP || state_d == S_WR_LOW || state_d == S_WR_HOLD;
        tx_wptr_d = tx_wptr_q + TX_AW'(tx_push);
        tx_rptr_d = tx_rptr_q + TX_AW'(tx_pop);
        tx_used_d = tx_used_q + (TX_AW+1)'(tx_push) - (TX_AW+1)'(tx_pop);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rxf_sync_q <= '1;
            txe_sync_q <= '1;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            last_wr_q  <= 1'b1;
            rd_data_q  <= '0;
            rd_pend_q  <= 1'b0;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            oe_q       <= 1'b0;
            out_q      <= '0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_used_q  <= '0;
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_used_q  <= '0;
        end else begin
            rxf_sync_q <= rxf_sync_d;
            txe_sync_q <= txe_sync_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_wr_q  <= last_wr_d;
            rd_data_q  <= rd_data_d;
            rd_pend_q  <= rd_pend_d;
            rd_n_q     <= rd_n_d;
            wr_n_q     <= wr_n_d;
            oe_q       <= oe_d;
            out_q      <= out_d;
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            rx_used_q  <= rx_used_d;
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            tx_used_q  <= tx_used_d;
        end
    end

    always_ff @(posedge clock) begin
        if (rx_push) rx_mem_q[rx_wptr_q] <= rd_data_q;
        if (tx_push) tx_mem_q[tx_wptr_q] <= tx_data;
    end

`ifdef FTDI_BRIDGE_STATS_EN
    logic [15:0] rx_count_q, rx_count_d, tx_count_q, tx_count_d;
    always_comb begin
        rx_count_d = rx_count_q + 16'(rx_push);
        tx_count_d = tx_count_q + 16'(tx_pop);
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_count_q <= '0;
            tx_count_q <= '0;
        end else begin
            rx_count_q <= rx_count_d;
            tx_count_q <= tx_count_d;
        end
    end
    assign rx_count = rx_count_q;
    assign tx_count = tx_count_q;
`else
    assign rx_count = '0;
    assign tx_count = '0;
`endif
endmodule

// File: tb/tb_ftdi_fifo_bridge.sv
// tb_ftdi_fifo_bridge: randomized bench with a queue-based FT232H host model and stream scoreboard.
module tb_ftdi_fifo_bridge;
    typedef logic [7:0] bq_t[$];

    logic clock = 0, reset = 0, ftdi_rxf = 1, ftdi_txe = 1;
    logic ftdi_rd, ftdi_wr, adbus_oe, rx_valid, tx_ready, busy;
    logic rx_ready = 0, tx_valid = 0;
    logic [7:0] adbus_in = 0, adbus_out, rx_data, tx_data = 0;
    logic [15:0] rx_count, tx_count;

    int passed = 0, total = 0;
    int cyc = 0, n_rd = 0, n_wr = 0, rd_fall_cyc = 0, last_rd_len = 0, last_rd_gap = 0;
    int overlap_err = 0, spurious = 0;
    bq_t host_q, exp_rx, got_rx, tx_exp, wr_seen;
    bit seq[$];

    ftdi_fifo_bridge dut (
        .clock(clock), .reset(reset), .ftdi_rxf(ftdi_rxf), .ftdi_txe(ftdi_txe),
        .ftdi_rd(ftdi_rd), .ftdi_wr(ftdi_wr), .adbus_in(adbus_in), .adbus_out(adbus_out),
        .adbus_oe(adbus_oe), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
        .rx_count(rx_count), .tx_count(tx_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    function automatic void host_sync();
        ftdi_rxf = (host_q.size() == 0);
        adbus_in = (host_q.size() != 0) ? host_q[0] : 8'h00;
    endfunction

    function automatic int qdiff(input bq_t a, input bq_t b);
        int d = (a.size() != b.size()) ? 1 : 0;
        foreach (a[i]) if (i < b.size() && a[i] !== b[i]) d++;
        return d;
    endfunction

    // Host side of the async-245 bus: a byte is consumed when rd rises, captured when wr rises.
    always @(negedge ftdi_rd) if (!reset) begin
        n_rd++;
        seq.push_back(1'b1);
        last_rd_gap = cyc - rd_fall_cyc;
        rd_fall_cyc = cyc;
    end
    always @(posedge ftdi_rd) if (!reset) begin
        last_rd_len = cyc - rd_fall_cyc;
        if (host_q.size() == 0) spurious++;
        else exp_rx.push_back(host_q.pop_front());
        host_sync();
    end
    always @(negedge ftdi_wr) if (!reset) seq.push_back(1'b0);
    always @(posedge ftdi_wr) if (!reset) begin
        n_wr++;
        wr_seen.push_back(adbus_out);
    end
    always @(negedge clock) if (!reset && !ftdi_rd && (!ftdi_wr || adbus_oe)) overlap_err++;

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic load_host(input int n);
        for (int i = 0; i < n; i++) host_q.push_back(8'($urandom));
        host_sync();
    endtask

    task automatic push_tx(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1);
            tx_valid = 1;
            tx_data  = 8'($urandom);
            if (tx_ready) tx_exp.push_back(tx_data);
        end
        tick(1);
        tx_valid = 0;
    endtask

    task automatic wait_wr(input int n, output bit ok);
        ok = 0;
        for (int t = 0; t < 600; t++) begin
            if (wr_seen.size() >= n && !busy) begin ok = 1; break; end
            tick(1);
        end
    endtask

    task automatic drain_rx(output bit ok);
        ok = 0;
        rx_ready = 1;
        for (int t = 0; t < 600; t++) begin
            if (rx_valid) got_rx.push_back(rx_data);
            else if (host_q.size() == 0 && !busy) begin ok = 1; break; end
            tick(1);
        end
        rx_ready = 0;
    endtask

    task automatic clear_model();
        exp_rx.delete(); got_rx.delete(); tx_exp.delete(); wr_seen.delete(); seq.delete();
    endtask

    task automatic test_reset();
        bit bad = 0;
        reset = 1;
        #1;
        total++; if (ftdi_rd !== 1'b1) $display("FAIL rst_rd got=%0h want=1", ftdi_rd); else passed++;
        total++; if (ftdi_wr !== 1'b1) $display("FAIL rst_wr got=%0h want=1", ftdi_wr); else passed++;
        total++; if (adbus_oe !== 1'b0) $display("FAIL rst_oe got=%0h want=0", adbus_oe); else passed++;
        total++; if (adbus_out !== 8'h00) $display("FAIL rst_out got=%0h want=0", adbus_out); else passed++;
        total++; if (rx_valid !== 1'b0) $display("FAIL rst_rx_valid got=%0h want=0", rx_valid); else passed++;
        total++; if (tx_ready !== 1'b1) $display("FAIL rst_tx_ready got=%0h want=1", tx_ready); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rst_busy got=%0h want=0", busy); else passed++;
        total++; if ({rx_count, tx_count} !== 32'h0) $display("FAIL rst_counts got=%0h want=0", {rx_count, tx_count}); else passed++;
        tick(2);
        reset = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (ftdi_rd !== 1 || ftdi_wr !== 1 || adbus_oe !== 0 || busy !== 0) bad = 1;
        end
        total++; if (bad !== 1'b0) $display("FAIL idle_quiet got=%0h want=0", bad); else passed++;
    endtask

    task automatic test_single_read();
        int t = 0, n0 = n_rd;
        clear_model();
        host_q.push_back(8'hA5);
        host_sync();
        while (!rx_valid && t < 60) begin tick(1); t++; end
        total++; if (rx_valid !== 1'b1) $display("FAIL rd1_valid got=%0h want=1", rx_valid); else passed++;
        total++; if (rx_data !== 8'hA5) $display("FAIL rd1_data got=%0h want=a5", rx_data); else passed++;
        total++; if (n_rd - n0 !== 1) $display("FAIL rd1_pulses got=%0d want=1", n_rd - n0); else passed++;
        total++; if (last_rd_len !== 3) $display("FAIL rd1_len got=%0d want=3", last_rd_len); else passed++;
        rx_ready = 1;
        tick(1);
        rx_ready = 0;
        total++; if (rx_valid !== 1'b0) $display("FAIL rd1_pop got=%0h want=0", rx_valid); else passed++;
    endtask

    task automatic test_turnaround();
        int t = 0, n0 = n_rd;
        bit ok;
        clear_model();
        load_host(2);
        while ((n_rd < n0 + 2 || busy) && t < 100) begin tick(1); t++; end
        total++; if (n_rd - n0 !== 2) $display("FAIL turn_reads got=%0d want=2", n_rd - n0); else passed++;
        total++; if (last_rd_gap !== 7) $display("FAIL turn_gap got=%0d want=7", last_rd_gap); else passed++;
        drain_rx(ok);
        total++; if (ok !== 1'b1) $display("FAIL turn_drain got=%0h want=1", ok); else passed++;
        total++; if (qdiff(got_rx, exp_rx) !== 0) $display("FAIL turn_data got=%0d want=0 diffs", qdiff(got_rx, exp_rx)); else passed++;
    endtask

    task automatic test_single_write();
        int c_oe = -1, c_wl = -1, wl = 0, phase = 0;
        bit rdy_bad = 0, data_bad = 0, hold_ok = 0, after_ok = 0;
        clear_model();
        tick(1);
        tx_valid = 1;
        tx_data = 8'h3C;
        tick(1);
        tx_valid = 0;
        ftdi_txe = 0;
        for (int t = 0; t < 40; t++) begin
            tick(1);
            if (!tx_ready) rdy_bad = 1;
            if (adbus_oe && c_oe < 0) c_oe = t;
            if (!ftdi_wr) begin
                if (c_wl < 0) c_wl = t;
                wl++;
                if (adbus_out !== 8'h3C) data_bad = 1;
            end else if (wl > 0 && phase == 0) begin
                phase = 1;
                hold_ok = adbus_oe && adbus_out == 8'h3C;
            end else if (phase == 1) begin
                phase = 2;
                after_ok = !adbus_oe;
            end
        end
        ftdi_txe = 1;
        total++; if (c_wl - c_oe !== 1) $display("FAIL wr1_setup got=%0d want=1", c_wl - c_oe); else passed++;
        total++; if (wl !== 2) $display("FAIL wr1_low got=%0d want=2", wl); else passed++;
        total++; if (data_bad !== 1'b0) $display("FAIL wr1_data got=%0h want=0", data_bad); else passed++;
        total++; if (hold_ok !== 1'b1) $display("FAIL wr1_hold got=%0h want=1", hold_ok); else passed++;
        total++; if (after_ok !== 1'b1) $display("FAIL wr1_oe_off got=%0h want=1", after_ok); else passed++;
        total++; if (rdy_bad !== 1'b0) $display("FAIL wr1_tx_ready got=%0h want=0", rdy_bad); else passed++;
        total++; if (wr_seen.size() !== 1 || wr_seen[0] !== 8'h3C) $display("FAIL wr1_host got=%0d want=1 byte 3c", wr_seen.size()); else passed++;
    endtask

    task automatic test_alternate();
        int t = 0, ov0 = overlap_err;
        bit bad, ok1, ok2;
        clear_model();
        push_tx(4);
        seq.delete();
        load_host(4);
        ftdi_txe = 0;
        while ((seq.size() < 8 || busy) && t < 400) begin tick(1); t++; end
        bad = seq.size() != 8;
        foreach (seq[i]) if (seq[i] != (i % 2 == 0)) bad = 1;
        total++; if (bad !== 1'b0) $display("FAIL alt_order got=%0d strobes want=8 alternating", seq.size()); else passed++;
        total++; if (overlap_err !== ov0) $display("FAIL alt_overlap got=%0d want=%0d", overlap_err, ov0); else passed++;
        wait_wr(4, ok1);
        ftdi_txe = 1;
        total++; if (qdiff(wr_seen, tx_exp) !== 0 || !ok1) $display("FAIL alt_wdata got=%0d want=0 diffs", qdiff(wr_seen, tx_exp)); else passed++;
        drain_rx(ok2);
        total++; if (qdiff(got_rx, exp_rx) !== 0 || !ok2) $display("FAIL alt_rdata got=%0d want=0 diffs", qdiff(got_rx, exp_rx)); else passed++;
    endtask

    task automatic test_rx_full();
        int n0 = n_rd;
        bit ok;
        clear_model();
        load_host(10);
        tick(250);
        total++; if (n_rd - n0 !== 8) $display("FAIL full_reads got=%0d want=8", n_rd - n0); else passed++;
        total++; if (rx_valid !== 1'b1) $display("FAIL full_valid got=%0h want=1", rx_valid); else passed++;
        total++; if (ftdi_rxf !== 1'b0 || host_q.size() !== 2) $display("FAIL full_pending got=%0d want=2", host_q.size()); else passed++;
        rx_ready = 1;
        got_rx.push_back(rx_data);
        tick(1);
        rx_ready = 0;
        tick(60);
        total++; if (n_rd - n0 !== 9) $display("FAIL full_refill got=%0d want=9", n_rd - n0); else passed++;
        drain_rx(ok);
        total++; if (qdiff(got_rx, exp_rx) !== 0 || got_rx.size() !== 10 || !ok) $display("FAIL full_data got=%0d bytes want=10", got_rx.size()); else passed++;
    endtask

    task automatic test_tx_full();
        bit ok;
        clear_model();
        for (int i = 0; i < 12; i++) begin
            tick(1);
            tx_valid = 1;
            tx_data = 8'($urandom);
            if (tx_ready) tx_exp.push_back(tx_data);
        end
        tick(1);
        tx_valid = 0;
        total++; if (tx_exp.size() !== 8) $display("FAIL txfull_accepted got=%0d want=8", tx_exp.size()); else passed++;
        total++; if (tx_ready !== 1'b0) $display("FAIL txfull_ready got=%0h want=0", tx_ready); else passed++;
        ftdi_txe = 0;
        wait_wr(8, ok);
        ftdi_txe = 1;
        total++; if (qdiff(wr_seen, tx_exp) !== 0 || !ok) $display("FAIL txfull_data got=%0d want=0 diffs", qdiff(wr_seen, tx_exp)); else passed++;
        total++; if (tx_ready !== 1'b1) $display("FAIL txfull_empty got=%0h want=1", tx_ready); else passed++;
    endtask

    task automatic test_random();
        int sp0 = spurious, ov0 = overlap_err;
        bit ok1, ok2;
        clear_model();
        for (int i = 0; i < 800; i++) begin
            tick(1);
            if ($urandom_range(0, 5) == 0 && host_q.size() < 4) begin
                host_q.push_back(8'($urandom));
                host_sync();
            end
            if ($urandom_range(0, 7) == 0) ftdi_txe = ~ftdi_txe;
            tx_valid = 1'($urandom_range(0, 1));
            tx_data = 8'($urandom);
            if (tx_valid && tx_ready) tx_exp.push_back(tx_data);
            rx_ready = 1'($urandom_range(0, 1));
            if (rx_valid && rx_ready) got_rx.push_back(rx_data);
        end
        tick(1);
        tx_valid = 0;
        rx_ready = 0;
        ftdi_txe = 0;
        wait_wr(tx_exp.size(), ok1);
        drain_rx(ok2);
        ftdi_txe = 1;
        total++; if (qdiff(wr_seen, tx_exp) !== 0 || !ok1) $display("FAIL rnd_wdata got=%0d want=0 diffs", qdiff(wr_seen, tx_exp)); else passed++;
        total++; if (qdiff(got_rx, exp_rx) !== 0 || !ok2) $display("FAIL rnd_rdata got=%0d want=0 diffs", qdiff(got_rx, exp_rx)); else passed++;
        total++; if (spurious !== sp0) $display("FAIL rnd_spurious got=%0d want=%0d", spurious, sp0); else passed++;
        total++; if (overlap_err !== ov0) $display("FAIL rnd_overlap got=%0d want=%0d", overlap_err, ov0); else passed++;
    endtask

    task automatic test_reset_mid_write();
        int t = 0, w0;
        clear_model();
        push_tx(2);
        ftdi_txe = 0;
        while (ftdi_wr && t < 60) begin tick(1); t++; end
        total++; if (ftdi_wr !== 1'b0) $display("FAIL mid_reach got=%0h want=0", ftdi_wr); else passed++;
        reset = 1;
        #1;
        total++; if (ftdi_wr !== 1'b1) $display("FAIL mid_wr got=%0h want=1", ftdi_wr); else passed++;
        total++; if (adbus_oe !== 1'b0) $display("FAIL mid_oe got=%0h want=0", adbus_oe); else passed++;
        tick(1);
        reset = 0;
        w0 = n_wr;
        tick(40);
        total++; if (n_wr !== w0) $display("FAIL mid_tx_empty got=%0d want=%0d", n_wr, w0); else passed++;
        total++; if (tx_ready !== 1'b1 || busy !== 1'b0) $display("FAIL mid_state got=%0h want=2", {tx_ready, busy}); else passed++;
        total++; if ({rx_count, tx_count} !== 32'h0) $display("FAIL mid_counts got=%0h want=0", {rx_count, tx_count}); else passed++;
        ftdi_txe = 1;
    endtask

    task automatic test_stats();
        int t = 0, n0 = n_rd;
        bit ok1, ok2;
        logic [15:0] want_rx, want_tx;
        clear_model();
        load_host(3);
        push_tx(2);
        while ((n_rd < n0 + 3 || busy) && t < 150) begin tick(1); t++; end
        ftdi_txe = 0;
        wait_wr(2, ok1);
        ftdi_txe = 1;
`ifdef FTDI_BRIDGE_STATS_EN
        want_rx = 16'(exp_rx.size());
        want_tx = 16'(wr_seen.size());
`else
        want_rx = 16'h0;
        want_tx = 16'h0;
`endif
        total++; if (n_rd - n0 !== 3) $display("FAIL stats_reads got=%0d want=3", n_rd - n0); else passed++;
        total++; if (rx_count !== want_rx) $display("FAIL stats_rx got=%0d want=%0d", rx_count, want_rx); else passed++;
        total++; if (tx_count !== want_tx) $display("FAIL stats_tx got=%0d want=%0d", tx_count, want_tx); else passed++;
        total++; if (qdiff(wr_seen, tx_exp) !== 0 || !ok1) $display("FAIL stats_wdata got=%0d want=0 diffs", qdiff(wr_seen, tx_exp)); else passed++;
        drain_rx(ok2);
        total++; if (qdiff(got_rx, exp_rx) !== 0 || !ok2) $display("FAIL stats_rdata got=%0d want=0 diffs", qdiff(got_rx, exp_rx)); else passed++;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        test_reset();
        test_single_read();
        test_turnaround();
        test_single_write();
        test_alternate();
        test_rx_full();
        test_tx_full();
        test_random();
        test_reset_mid_write();
        test_stats();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
